// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: channel map, default timing constants and width helper for the key conditioner.
package key_conditioner_pkg;
  localparam int KC_CH = 18;
  localparam int CH_NOTE_LSB = 0;
  localparam int CH_LEN_LSB = 7;
  localparam int CH_SUBMIT = 14;
  localparam int CH_CANCEL = 15;
  localparam int CH_OCT_UP = 16;
  localparam int CH_OCT_DOWN = 17;
  localparam int KC_TICK_CYCLES = 100000;
  localparam int KC_STABLE_TICKS = 20;
  localparam int KC_REPEAT_DELAY = 500;
  localparam int KC_REPEAT_PERIOD = 100;
  typedef logic [KC_CH-1:0] kc_vec_t;
  localparam kc_vec_t KC_REPEAT_MASK = 18'h30000;
  function automatic int kc_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw switch inputs and conditioned level/edge outputs of the key conditioner.
interface key_conditioner_if #(parameter int CH = key_conditioner_pkg::KC_CH);
  logic [CH-1:0] raw;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic any_rise;
  logic tick;
  modport master(output raw, input level, rise, fall, any_rise, tick);
  modport slave(input raw, output level, rise, fall, any_rise, tick);
endinterface

// File: rtl/key_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchronizer, tick-sampled debounce and edge pulses for one input.
// Hold-repeat of rise pulses is built only with KEY_CONDITIONER_HOLD_REPEAT_EN.
module debounce_channel
  import key_conditioner_pkg::*;
#(
  parameter int STABLE_TICKS = KC_STABLE_TICKS
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
  , parameter int REPEAT_DELAY = KC_REPEAT_DELAY
  , parameter int REPEAT_PERIOD = KC_REPEAT_PERIOD
  , parameter bit REPEAT_EN = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);
  localparam int CW = kc_width(STABLE_TICKS + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic differ, accept, rep;
  assign differ = sync[1] != level;
  assign accept = tick && differ && cnt == CW'(STABLE_TICKS - 1);
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
  localparam int RW = kc_width(REPEAT_DELAY + 1);
  logic [RW-1:0] rcnt;
  assign rep = REPEAT_EN && level && tick && rcnt == RW'(REPEAT_DELAY - 1);
  always_ff @(posedge clk)
    if (rst || !REPEAT_EN || !level) rcnt <= '0;
    else if (tick) rcnt <= rep ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rcnt + 1'b1;
`else
  assign rep = 1'b0;
`endif
  assign rise_nxt = (accept && !level) || rep;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= rise_nxt;
      fall <= accept && level;
      if (tick) begin
        cnt <= (!differ || accept) ? '0 : cnt + 1'b1;
        if (accept) level <= sync[1];
      end
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: free-running sample tick plus CH independent debounce channels.
// Optional hold-repeat on REPEAT_MASK channels via KEY_CONDITIONER_HOLD_REPEAT_EN.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int CH = KC_CH,
  parameter int TICK_CYCLES = KC_TICK_CYCLES,
  parameter int STABLE_TICKS = KC_STABLE_TICKS
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
  , parameter int REPEAT_DELAY = KC_REPEAT_DELAY
  , parameter int REPEAT_PERIOD = KC_REPEAT_PERIOD
  , parameter logic [CH-1:0] REPEAT_MASK = CH'(KC_REPEAT_MASK)
`endif
) (
  input logic clk,
  input logic rst,
  key_conditioner_if.slave bus
);
  localparam int TW = kc_width(TICK_CYCLES);
  logic [TW-1:0] tcnt;
  logic tick, any_rise;
  logic [CH-1:0] level_v, rise_v, fall_v, rise_nxt;
  assign tick = tcnt == TW'(TICK_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      any_rise <= 1'b0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      any_rise <= |rise_nxt;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
      , .REPEAT_EN(REPEAT_MASK[i])
`endif
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(bus.raw[i]),
      .tick(tick),
      .level(level_v[i]),
      .rise(rise_v[i]),
      .fall(fall_v[i]),
      .rise_nxt(rise_nxt[i])
    );
  end
  assign bus.level = level_v;
  assign bus.rise = rise_v;
  assign bus.fall = fall_v;
  assign bus.any_rise = any_rise;
  assign bus.tick = tick;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random stimulus against a tick-level behavioural model.
module tb_key_conditioner;
  localparam int CH = 18;
  localparam int T = 4;
  localparam int S = 3;
  localparam int RD = 5;
  localparam int RP = 2;
  localparam logic [CH-1:0] MASK = 18'h30000;
  localparam logic [CH-1:0] ALL = '1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] raw = '0;
  int checks = 0;
  int errors = 0;
  logic [CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  int m_run [CH];
  int m_hold [CH];
  int m_tc;
  key_conditioner_if #(.CH(CH)) bus ();
  assign bus.raw = raw;
  key_conditioner #(
    .CH(CH), .TICK_CYCLES(T), .STABLE_TICKS(S)
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_edge();
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_tc = 0;
      for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (m_tc == T - 1) begin
        for (int c = 0; c < CH; c++) begin
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
          if (MASK[c] && m_lvl[c]) begin
            m_hold[c]++;
            if (m_hold[c] >= RD && (m_hold[c] - RD) % RP == 0) m_rise[c] = 1'b1;
          end else m_hold[c] = 0;
`endif
          m_run[c] = (m_s2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
          if (m_run[c] == S) begin
            m_lvl[c] = m_s2[c];
            m_run[c] = 0;
            if (m_lvl[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
          end
        end
      end
      m_tc = (m_tc + 1) % T;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("level", bus.level, m_lvl);
    chk("rise", bus.rise, m_rise);
    chk("fall", bus.fall, m_fall);
    chk("any_rise", bus.any_rise, |m_rise);
    chk("tick", bus.tick, m_tc == T - 1);
  endtask
  task automatic wait_lvl(input int c, input logic v, output int n);
    n = 0;
    while (bus.level[c] !== v && n < 40) begin cyc(); n++; end
    chk($sformatf("wait_level_%0d", c), bus.level[c], v);
  endtask
  initial begin
    int n, r, f, t0, t7, exp_rep;
    logic got;
    raw = ALL;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin cyc(); n++; got = bus.level == ALL; end
    chk("reset_requalify_latency", got && n >= 11, 1'b1);
    chk("reset_requalify_rise", bus.rise, ALL);
    raw = '0;
    repeat (20) cyc();
    chk("all_released", bus.level, '0);
    raw[14] = 1'b1;
    wait_lvl(14, 1'b1, n);
    chk("submit_latency", n >= 11 && n <= 15, 1'b1);
    chk("submit_rise", bus.rise, 18'h04000);
    chk("submit_any_rise", bus.any_rise, 1'b1);
    cyc();
    chk("submit_rise_one_cycle", bus.rise, '0);
    r = 0;
    raw[3] = 1'b1;
    repeat (8) begin cyc(); r += int'(bus.rise[3]); end
    raw[3] = 1'b0;
    repeat (4) begin cyc(); r += int'(bus.rise[3]); end
    chk("bounce_no_early_rise", r, 0);
    raw[3] = 1'b1;
    repeat (20) begin cyc(); r += int'(bus.rise[3]); end
    chk("bounce_single_rise", r, 1);
    chk("bounce_level", bus.level[3], 1'b1);
    raw[15] = 1'b1;
    wait_lvl(15, 1'b1, n);
    raw[15] = 1'b0;
    r = 0;
    f = 0;
    repeat (20) begin cyc(); r += int'(bus.rise[15]); f += int'(bus.fall[15]); end
    chk("cancel_fall_once", f, 1);
    chk("cancel_no_rise", r, 0);
    chk("cancel_level", bus.level[15], 1'b0);
    raw[0] = 1'b1;
    raw[7] = 1'b1;
    t0 = -1;
    t7 = -1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.rise[0] && t0 < 0) t0 = k;
      if (bus.rise[7] && t7 < 0) t7 = k;
    end
    chk("simul_rise_seen", t0 >= 0, 1'b1);
    chk("simul_rise_same_cycle", t0, t7);
    raw[16] = 1'b1;
    wait_lvl(16, 1'b1, n);
    r = 0;
    f = 0;
    repeat (60) begin cyc(); r += int'(bus.rise[16]); f += int'(bus.rise[14]); end
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
    exp_rep = 6;
`else
    exp_rep = 0;
`endif
    chk("oct_up_repeats", r, exp_rep);
    chk("submit_no_repeat", f, 0);
    raw[9] = 1'b1;
    repeat (8) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    chk("mid_reset_level", bus.level, '0);
    rst = 1'b0;
    wait_lvl(9, 1'b1, n);
    chk("mid_reset_requalify", n >= 11, 1'b1);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(15) == 0) raw[$urandom_range(CH - 1)] ^= 1'b1;
      if ($urandom_range(63) == 0) raw ^= CH'($urandom);
      rst = $urandom_range(999) == 0;
      cyc();
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
